// File: rtl/nibble_serial_adder_ctrl.sv
// Serial WIDTH-bit add/subtract that reuses one 4-bit carry-lookahead slice.
// Nibbles are processed LSB first, one per clock, with valid/ready on both sides.

module nibble_serial_adder_ctrl_cla4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_s,
  output logic       o_p,
  output logic       o_g
);
  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [3:0] w_c;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  assign w_c[0] = i_cin;
  assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);

  assign o_s = w_p ^ w_c;
  assign o_p = &w_p;
  assign o_g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
             | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
endmodule

// State table:
//   S_IDLE | waiting for a command, start_ready high
//   S_RUN  | one nibble per clock through the shared slice, busy high
//   S_DONE | result held until the consumer takes it, res_valid high
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [IW-1:0]    r_idx;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic             w_accept;
  logic             w_step;
  logic             w_last;
  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [3:0]       w_s_nib;
  logic             w_p;
  logic             w_g;
  logic             w_carry_nxt;
  logic [WIDTH-1:0] w_sum_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    start_ready = 1'b0;
    busy        = 1'b0;
    res_valid   = 1'b0;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      S_IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy   = 1'b1;
        w_step = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_last  = (r_idx == LAST);
  assign w_a_nib = r_a[{r_idx, 2'b00} +: 4];
  assign w_b_nib = r_b[{r_idx, 2'b00} +: 4];

  nibble_serial_adder_ctrl_cla4 u_slice (
    .i_a   (w_a_nib),
    .i_b   (w_b_nib),
    .i_cin (r_carry),
    .o_s   (w_s_nib),
    .o_p   (w_p),
    .o_g   (w_g)
  );

  assign w_carry_nxt = w_g | (w_p & r_carry);

  // Full sum including the nibble written this edge, so flags see the final value.
  always_comb begin
    w_sum_nxt = r_sum;
    w_sum_nxt[{r_idx, 2'b00} +: 4] = w_s_nib;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub;
      r_idx   <= '0;
      r_sum   <= '0;
    end else if (w_step) begin
      r_sum   <= w_sum_nxt;
      r_carry <= w_carry_nxt;
      if (w_last) begin
        r_idx  <= '0;
        r_cout <= w_carry_nxt;
        r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum_nxt[WIDTH-1] != r_a[WIDTH-1]);
        r_zero <= (w_sum_nxt == '0);
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;
  assign zero = r_zero;
endmodule
